// File: rtl/conv_sched_pkg.sv
// Shared types for the ping/pong frame scheduler in front of the convolution engine.
package conv_sched_pkg;

    // Lifecycle of one image bank: loaded by the streamer, then consumed by the engine.
    typedef enum logic [1:0] {
        EMPTY     = 2'b00,
        FILLING   = 2'b01,
        FULL      = 2'b10,
        COMPUTING = 2'b11
    } bank_state_t;

    localparam int NUM_BANKS = 2;

endpackage

// File: rtl/conv_pp_bank_fsm.sv
// State of a single image bank. The top decides which bank each event targets;
// this block only sequences EMPTY -> FILLING -> FULL -> COMPUTING -> EMPTY.
module conv_pp_bank_fsm
    import conv_sched_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        fill_start,
    input  logic        fill_end,
    input  logic        start,
    input  logic        free,
    output bank_state_t state
);

    bank_state_t state_r;
    bank_state_t state_next_s;

    // Bank state register, cleared by the shared synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; fill_end wins over fill_start so a one-beat frame goes straight to FULL.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            EMPTY: begin
                if (fill_end) begin
                    state_next_s = FULL;
                end else if (fill_start) begin
                    state_next_s = FILLING;
                end else begin
                    state_next_s = EMPTY;
                end
            end
            FILLING: begin
                if (fill_end) begin
                    state_next_s = FULL;
                end else begin
                    state_next_s = FILLING;
                end
            end
            FULL: begin
                if (start) begin
                    state_next_s = COMPUTING;
                end else begin
                    state_next_s = FULL;
                end
            end
            COMPUTING: begin
                if (free) begin
                    state_next_s = EMPTY;
                end else begin
                    state_next_s = COMPUTING;
                end
            end
            default: begin
                state_next_s = EMPTY;
            end
        endcase
    end

    assign state = state_r;

endmodule

// File: rtl/conv_pingpong_sched.sv
// Ping/pong frame scheduler: streams loader beats into the free image bank, hands
// full banks to the convolution engine in fill order, and counts result writes to
// detect frame completion and release the bank.
module conv_pingpong_sched
    import conv_sched_pkg::*;
#(
    parameter  int DATA_WIDTH         = 8,
    parameter  int IMG_W              = 8,
    parameter  int IMG_H              = 8,
    parameter  int IMG_D              = 4,
    parameter  int RESULT_W           = 6,
    parameter  int RESULT_H           = 6,
    parameter  int DONE_CNT_W         = 16,
    localparam int PIX                = IMG_W * IMG_H,
    localparam int RES                = RESULT_W * RESULT_H,
    localparam int IMG_RAM_ADDR_WIDTH = $clog2(PIX)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_val,
    output logic                          load_rdy,
    input  logic [DATA_WIDTH*IMG_D-1:0]   load_data,
    input  logic                          load_last,
    output logic [IMG_RAM_ADDR_WIDTH-1:0] img_wraddress,
    output logic [DATA_WIDTH*IMG_D-1:0]   img_wrdata,
    output logic [NUM_BANKS-1:0]          img_wren,
    output logic                          eng_bank_sel,
    output logic                          eng_val_in,
    input  logic                          eng_rdy_in,
    input  logic                          result_wren,
    output logic                          frame_done,
    output logic [DONE_CNT_W-1:0]         done_count,
    output logic                          err_last
);

    localparam int RES_CNT_W = (RES > 1) ? $clog2(RES) : 1;
    localparam logic [IMG_RAM_ADDR_WIDTH-1:0] LAST_BEAT = IMG_RAM_ADDR_WIDTH'(PIX - 1);
    localparam logic [RES_CNT_W-1:0]          LAST_RES  = RES_CNT_W'(RES - 1);

    bank_state_t                   bank_state_s [NUM_BANKS];
    logic [NUM_BANKS-1:0]          fill_start_s;
    logic [NUM_BANKS-1:0]          fill_end_s;
    logic [NUM_BANKS-1:0]          start_s;
    logic [NUM_BANKS-1:0]          free_s;
    logic [NUM_BANKS-1:0]          wr_onehot_s;
    logic [NUM_BANKS-1:0]          rd_onehot_s;
    logic                          load_rdy_s;
    logic                          accept_s;
    logic                          last_beat_s;
    logic                          eng_val_s;
    logic                          handshake_s;
    logic                          res_hit_s;
    logic                          res_last_s;

    logic                          wr_bank_r;
    logic                          rd_bank_r;
    logic [IMG_RAM_ADDR_WIDTH-1:0] beat_cnt_r;
    logic [RES_CNT_W-1:0]          res_cnt_r;
    logic [IMG_RAM_ADDR_WIDTH-1:0] img_wraddress_r;
    logic [DATA_WIDTH*IMG_D-1:0]   img_wrdata_r;
    logic [NUM_BANKS-1:0]          img_wren_r;
    logic                          eng_bank_sel_r;
    logic                          frame_done_r;
    logic [DONE_CNT_W-1:0]         done_count_r;
    logic                          err_last_r;

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        conv_pp_bank_fsm u_bank_fsm (
            .clk        (clk),
            .reset      (reset),
            .fill_start (fill_start_s[g]),
            .fill_end   (fill_end_s[g]),
            .start      (start_s[g]),
            .free       (free_s[g]),
            .state      (bank_state_s[g])
        );
    end

    // Handshake decode and per-bank event steering from the registered pointers and states.
    always_comb begin
        load_rdy_s = 1'b0;
        case (bank_state_s[wr_bank_r])
            EMPTY, FILLING: load_rdy_s = 1'b1;
            default:        load_rdy_s = 1'b0;
        endcase
        wr_onehot_s  = wr_bank_r ? 2'b10 : 2'b01;
        rd_onehot_s  = rd_bank_r ? 2'b10 : 2'b01;
        accept_s     = load_val & load_rdy_s;
        last_beat_s  = (beat_cnt_r == LAST_BEAT);
        eng_val_s    = (bank_state_s[rd_bank_r] == FULL);
        handshake_s  = eng_val_s & eng_rdy_in;
        // Result pulses only count while the oldest bank is actually being convolved.
        res_hit_s    = result_wren & (bank_state_s[rd_bank_r] == COMPUTING);
        res_last_s   = res_hit_s & (res_cnt_r == LAST_RES);
        fill_start_s = (accept_s && (bank_state_s[wr_bank_r] == EMPTY)) ? wr_onehot_s : 2'b00;
        fill_end_s   = (accept_s && last_beat_s) ? wr_onehot_s : 2'b00;
        start_s      = handshake_s ? rd_onehot_s : 2'b00;
        free_s       = res_last_s ? rd_onehot_s : 2'b00;
    end

    // Load side: beat counter, write bank pointer, registered BRAM write port, load_last check.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank_r       <= 1'b0;
            beat_cnt_r      <= {IMG_RAM_ADDR_WIDTH{1'b0}};
            img_wren_r      <= {NUM_BANKS{1'b0}};
            img_wraddress_r <= {IMG_RAM_ADDR_WIDTH{1'b0}};
            img_wrdata_r    <= {(DATA_WIDTH*IMG_D){1'b0}};
            err_last_r      <= 1'b0;
        end else if (accept_s) begin
            img_wren_r      <= wr_onehot_s;
            img_wraddress_r <= beat_cnt_r;
            img_wrdata_r    <= load_data;
            // Frame boundaries come from the count alone; load_last is only cross-checked.
            if (load_last != last_beat_s) begin
                err_last_r <= 1'b1;
            end
            if (last_beat_s) begin
                beat_cnt_r <= {IMG_RAM_ADDR_WIDTH{1'b0}};
                wr_bank_r  <= ~wr_bank_r;
            end else begin
                beat_cnt_r <= beat_cnt_r + IMG_RAM_ADDR_WIDTH'(1);
            end
        end else begin
            img_wren_r <= {NUM_BANKS{1'b0}};
        end
    end

    // Engine side: latch the bank under computation, count results, release the bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_bank_r      <= 1'b0;
            res_cnt_r      <= {RES_CNT_W{1'b0}};
            eng_bank_sel_r <= 1'b0;
            frame_done_r   <= 1'b0;
            done_count_r   <= {DONE_CNT_W{1'b0}};
        end else begin
            if (handshake_s) begin
                eng_bank_sel_r <= rd_bank_r;
            end
            if (res_last_s) begin
                res_cnt_r    <= {RES_CNT_W{1'b0}};
                rd_bank_r    <= ~rd_bank_r;
                frame_done_r <= 1'b1;
                done_count_r <= done_count_r + DONE_CNT_W'(1);
            end else if (res_hit_s) begin
                res_cnt_r    <= res_cnt_r + RES_CNT_W'(1);
                frame_done_r <= 1'b0;
            end else begin
                frame_done_r <= 1'b0;
            end
        end
    end

    // load_rdy and eng_val_in decode registered state directly so a freed or filled
    // bank is visible to the loader/engine in the very next cycle.
    assign load_rdy      = load_rdy_s;
    assign eng_val_in    = eng_val_s;
    assign img_wren      = img_wren_r;
    assign img_wraddress = img_wraddress_r;
    assign img_wrdata    = img_wrdata_r;
    assign eng_bank_sel  = eng_bank_sel_r;
    assign frame_done    = frame_done_r;
    assign done_count    = done_count_r;
    assign err_last      = err_last_r;

endmodule

// File: tb/tb_conv_pingpong_sched.sv
// Scoreboard bench for conv_pingpong_sched with a 4x4 image and 2x2 result.
module tb_conv_pingpong_sched;

    localparam int PIX       = 16;
    localparam int STALL_MAX = 500;
    localparam int WAIT_MAX  = 2000;

    typedef struct {
        logic [1:0]  en;
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_val;
    logic        load_rdy;
    logic [31:0] load_data;
    logic        load_last;
    logic [3:0]  img_wraddress;
    logic [31:0] img_wrdata;
    logic [1:0]  img_wren;
    logic        eng_bank_sel;
    logic        eng_val_in;
    logic        eng_rdy_in;
    logic        result_wren;
    logic        frame_done;
    logic [15:0] done_count;
    logic        err_last;

    wr_exp_t wr_q[$];
    int      done_q[$];
    int      n_checks = 0;
    int      n_fail   = 0;
    int      cyc      = 0;
    logic    m_wr_bank;
    int      m_beat;
    int      m_done;
    int      last_acc_cyc;
    int      last_free_cyc;
    int      stall_sum;
    int      ld_st;
    int      f2_stall;
    int      f3_stall;
    int      f3_acc;
    int      f1_free;

    conv_pingpong_sched #(
        .DATA_WIDTH (8),
        .IMG_W      (4),
        .IMG_H      (4),
        .IMG_D      (4),
        .RESULT_W   (2),
        .RESULT_H   (2),
        .DONE_CNT_W (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .load_val      (load_val),
        .load_rdy      (load_rdy),
        .load_data     (load_data),
        .load_last     (load_last),
        .img_wraddress (img_wraddress),
        .img_wrdata    (img_wrdata),
        .img_wren      (img_wren),
        .eng_bank_sel  (eng_bank_sel),
        .eng_val_in    (eng_val_in),
        .eng_rdy_in    (eng_rdy_in),
        .result_wren   (result_wren),
        .frame_done    (frame_done),
        .done_count    (done_count),
        .err_last      (err_last)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to time-stamp acceptance and release events.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Output monitor: every BRAM write and every frame_done pulse is matched against the queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (img_wren != 2'b00) begin
                if (wr_q.size() == 0) begin
                    check_val("wr_unexpected", img_wren, 2'b00);
                end else begin
                    wr_exp_t e;
                    e = wr_q.pop_front();
                    check_val("wr_en", img_wren, e.en);
                    check_val("wr_addr", img_wraddress, e.addr);
                    check_val("wr_data", img_wrdata, e.data);
                end
            end
            if (frame_done) begin
                if (done_q.size() == 0) begin
                    check_val("done_unexpected", frame_done, 1'b0);
                end else begin
                    check_val("done_count", done_count, done_q.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1; load_val = 1'b0; load_last = 1'b0; load_data = 32'h0;
        result_wren = 1'b0; eng_rdy_in = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        wr_q.delete(); done_q.delete();
        m_wr_bank = 1'b0; m_beat = 0; m_done = 0;
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_wren", img_wren, 2'b00);
        check_val("rst_addr", img_wraddress, 4'h0);
        check_val("rst_data", img_wrdata, 32'h0);
        check_val("rst_val", eng_val_in, 1'b0);
        check_val("rst_sel", eng_bank_sel, 1'b0);
        check_val("rst_done", frame_done, 1'b0);
        check_val("rst_count", done_count, 16'h0);
        check_val("rst_err", err_last, 1'b0);
        check_val("rst_rdy", load_rdy, 1'b1);
        @(posedge clk); #1;
    endtask

    // One loader beat; pushes the expected write once load_rdy is seen ahead of the edge.
    task automatic send_beat(input logic last, output int stalls);
        wr_exp_t     e;
        logic [31:0] d;
        stalls = 0;
        d = $urandom();
        load_val = 1'b1; load_data = d; load_last = last;
        @(negedge clk);
        while (!load_rdy && stalls < STALL_MAX) begin
            stalls++;
            @(negedge clk);
        end
        if (load_rdy) begin
            e.en = m_wr_bank ? 2'b10 : 2'b01;
            e.addr = 4'(m_beat);
            e.data = d;
            wr_q.push_back(e);
            if (m_beat == PIX - 1) begin
                m_beat = 0;
                m_wr_bank = ~m_wr_bank;
            end else begin
                m_beat++;
            end
        end else begin
            check_val("rdy_timeout", load_rdy, 1'b1);
        end
        @(posedge clk); #1;
        last_acc_cyc = cyc;
        load_val = 1'b0; load_last = 1'b0;
    endtask

    task automatic send_run(input int n, output int total);
        int st;
        total = 0;
        for (int i = 0; i < n; i++) begin
            send_beat(m_beat == PIX - 1, st);
            total += st;
        end
    endtask

    task automatic engine_start(input logic exp_sel, input int hold);
        int w = 0;
        @(negedge clk);
        while (!eng_val_in && w < WAIT_MAX) begin
            w++;
            @(negedge clk);
        end
        check_val("val_wait", eng_val_in, 1'b1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_val("val_hold", eng_val_in, 1'b1);
        end
        eng_rdy_in = 1'b1;
        @(posedge clk); #1;
        eng_rdy_in = 1'b0;
        @(negedge clk);
        check_val("val_drop", eng_val_in, 1'b0);
        check_val("bank_sel", eng_bank_sel, exp_sel);
        @(posedge clk); #1;
    endtask

    task automatic pulse_result(input logic last);
        result_wren = 1'b1;
        if (last) begin
            m_done++;
            done_q.push_back(m_done);
        end
        @(posedge clk); #1;
        result_wren = 1'b0;
        last_free_cyc = cyc;
    endtask

    task automatic engine_results(input int gap);
        repeat (gap) begin @(posedge clk); #1; end
        for (int i = 0; i < 4; i++) pulse_result(i == 3);
    endtask

    // Hard stop in case some wait above is never bounded as intended.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        wr_exp_t     e;
        reset = 1'b1; load_val = 1'b0; load_data = 32'h0; load_last = 1'b0;
        eng_rdy_in = 1'b0; result_wren = 1'b0;
        @(posedge clk); #1;

        // 1: single frame, engine ready early, val rises right after the last beat.
        do_reset();
        eng_rdy_in = 1'b1;
        send_run(15, stall_sum);
        @(negedge clk);
        check_val("val_early", eng_val_in, 1'b0);
        @(posedge clk); #1;
        send_run(1, stall_sum);
        @(negedge clk);
        check_val("val_rise", eng_val_in, 1'b1);
        @(posedge clk); #1;
        eng_rdy_in = 1'b0;
        @(negedge clk);
        check_val("t1_val_drop", eng_val_in, 1'b0);
        check_val("t1_sel", eng_bank_sel, 1'b0);
        @(posedge clk); #1;
        engine_results(0);
        // Stray result pulse with nothing computing must be ignored.
        pulse_result(1'b0);
        repeat (3) begin @(posedge clk); #1; end
        check_val("t1_count", done_count, 16'd1);

        // 2: three frames back to back, 40-cycle engine.
        do_reset();
        f2_stall = 0;
        fork
            begin
                for (int f = 0; f < 3; f++) begin
                    for (int b = 0; b < PIX; b++) begin
                        send_beat(b == PIX - 1, ld_st);
                        if (f == 1) f2_stall += ld_st;
                        if (f == 2 && b == 0) begin
                            f3_stall = ld_st;
                            f3_acc = last_acc_cyc;
                        end
                    end
                end
            end
            begin
                for (int f = 0; f < 3; f++) begin
                    engine_start(f[0], 0);
                    engine_results(36);
                    if (f == 0) f1_free = last_free_cyc;
                end
            end
        join
        check_val("f2_stall", f2_stall, 0);
        check_val("f3_stalled", f3_stall > 0, 1'b1);
        check_val("f3_resume", f3_acc, f1_free + 1);
        repeat (3) begin @(posedge clk); #1; end
        check_val("t2_count", done_count, 16'd3);

        // 3: engine holds off for 10 cycles; val must stay up.
        do_reset();
        send_run(16, stall_sum);
        engine_start(1'b0, 10);
        engine_results(2);

        // 4: early load_last sets the sticky error but framing follows the count.
        do_reset();
        for (int b = 0; b < PIX; b++) begin
            send_beat(b == 9, ld_st);
            if (b == 8 || b == 9) begin
                @(negedge clk);
                check_val(b == 8 ? "err_before" : "err_set", err_last, b == 9);
                @(posedge clk); #1;
            end
        end
        send_run(16, stall_sum);
        check_val("err_sticky", err_last, 1'b1);
        engine_start(1'b0, 0);
        engine_results(1);
        engine_start(1'b1, 0);
        engine_results(1);
        @(negedge clk);
        check_val("err_sticky_end", err_last, 1'b1);
        @(posedge clk); #1;

        // 5: reset mid-frame clears everything; next frame restarts in bank 0 at address 0.
        send_run(7, stall_sum);
        do_reset();
        send_run(16, stall_sum);
        engine_start(1'b0, 0);
        engine_results(3);

        // 6: last result of bank 0 coincides with the last beat of bank 1.
        do_reset();
        send_run(16, stall_sum);
        engine_start(1'b0, 0);
        send_run(15, stall_sum);
        for (int i = 0; i < 3; i++) pulse_result(1'b0);
        d = $urandom();
        load_val = 1'b1; load_data = d; load_last = 1'b1; result_wren = 1'b1;
        @(negedge clk);
        check_val("coinc_rdy", load_rdy, 1'b1);
        e.en = 2'b10; e.addr = 4'd15; e.data = d;
        wr_q.push_back(e);
        m_beat = 0; m_wr_bank = 1'b0;
        m_done++;
        done_q.push_back(m_done);
        @(posedge clk); #1;
        load_val = 1'b0; load_last = 1'b0; result_wren = 1'b0;
        @(negedge clk);
        check_val("coinc_val", eng_val_in, 1'b1);
        check_val("coinc_free_rdy", load_rdy, 1'b1);
        check_val("coinc_done", frame_done, 1'b1);
        @(posedge clk); #1;
        engine_start(1'b1, 0);
        engine_results(2);

        repeat (5) begin @(posedge clk); #1; end
        check_val("wr_q_drain", wr_q.size(), 0);
        check_val("done_q_drain", done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
